rptr_sync_level: RTL

RPTR_SYNC_LEVEL -- requirements
Module: rptr_sync_level

---
 rtl/rptr_sync_level.sv | 78 +++++++
 1 files changed

// File: rtl/rptr_sync_level.sv
// rptr_sync_level: write-domain read-pointer synchronizer with fill-level, watermark and sticky status
module rptr_sync_level #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic                  winc,
  input  logic                  full,
  input  logic                  clr_stat,
  output logic [ADDR_WIDTH:0]   rptr_sync,
  output logic [ADDR_WIDTH:0]   rbin_sync,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   watermark,
  output logic                  overflow,
  output logic                  ptr_err
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rptr_prev, wbin, level_nxt, diff;
  logic          multi_bit, set_ovf, set_err;

  // plain flop chain carrying the read pointer into wclk, cleared on reset
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rptr_sync = sync_q[SYNC_STAGES-1];

  // pointer decode, modular level and integrity / overflow set conditions
  always_comb begin
    rbin_sync = g2b(rptr_sync);
    wbin      = g2b(wptr_gray);
    level_nxt = wbin - rbin_sync;
    diff      = rptr_sync ^ rptr_prev;
    multi_bit = |(diff & (diff - PW'(1)));
    set_ovf   = winc & full;
    set_err   = (level_nxt > DEPTH) | multi_bit;
  end

  // registered level/status; a set condition wins over a same-edge clear
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_prev   <= '0;
      wlevel      <= '0;
      almost_full <= 1'b0;
      watermark   <= '0;
      overflow    <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      rptr_prev   <= rptr_sync;
      wlevel      <= level_nxt;
      almost_full <= level_nxt >= AF;
      watermark   <= (clr_stat || level_nxt > watermark) ? level_nxt : watermark;
      overflow    <= set_ovf | (overflow & ~clr_stat);
      ptr_err     <= set_err | (ptr_err & ~clr_stat);
    end
  end
endmodule
